// File: rtl/count_chk_pkg.sv
// rtl/count_chk_pkg.sv - shared state encoding and default widths for the count checker
package count_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam int DEF_ERR_W  = 8;
   localparam int DEF_PASS_W = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - locks onto an incrementing count stream and flags broken increments
module count_checker
   import count_chk_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int SYNC_LEN = 2,
   parameter int ERR_W    = DEF_ERR_W,
   parameter int PASS_W   = DEF_PASS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              valid,
   output logic              locked,
   output logic              mismatch,
   output logic              error,
   output logic [WIDTH-1:0]  expected,
   output logic [ERR_W-1:0]  err_count,
   output logic [PASS_W-1:0] pass_count
);

   // Wide enough to hold SYNC_LEN itself, so run+1 never wraps before the compare.
   localparam int RUN_W = $clog2(SYNC_LEN + 1);

   state_t           r_state;
   logic [RUN_W-1:0] r_run;
   logic             r_locked;
   logic             r_mismatch;
   logic             r_error;
   logic [WIDTH-1:0] r_expected;

   logic             w_match;
   logic [WIDTH-1:0] w_resync;
   logic [RUN_W-1:0] w_run_nxt;
   logic             w_lock_hit;
   logic             w_lock_miss;

   assign w_match     = (count_in == r_expected);
   assign w_resync    = count_in + WIDTH'(1);
   assign w_run_nxt   = r_run + RUN_W'(1);
   assign w_lock_hit  = valid && (r_state == ST_LOCK) && w_match;
   assign w_lock_miss = valid && (r_state == ST_LOCK) && !w_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_run      <= '0;
         r_locked   <= 1'b0;
         r_mismatch <= 1'b0;
         r_error    <= 1'b0;
         r_expected <= '0;
      end else begin
         r_mismatch <= 1'b0;
         if (valid) begin
            case (r_state)
               ST_IDLE: begin
                  r_expected <= w_resync;
                  r_run      <= '0;
                  r_state    <= ST_SYNC;
               end
               ST_SYNC: begin
                  if (w_match) begin
                     r_run      <= w_run_nxt;
                     r_expected <= r_expected + WIDTH'(1);
                     if (w_run_nxt == RUN_W'(SYNC_LEN)) begin
                        r_state  <= ST_LOCK;
                        r_locked <= 1'b1;
                     end
                  end else begin
                     // Still acquiring: a miss just restarts alignment, it is not an error.
                     r_expected <= w_resync;
                     r_run      <= '0;
                  end
               end
               ST_LOCK: begin
                  if (w_match) begin
                     r_expected <= r_expected + WIDTH'(1);
                  end else begin
                     r_mismatch <= 1'b1;
                     r_error    <= 1'b1;
                     r_expected <= w_resync;
                     r_run      <= '0;
                     r_locked   <= 1'b0;
                     r_state    <= ST_SYNC;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_lock_miss),
      .q   (err_count)
   );

   sat_counter #(.W(PASS_W)) u_pass_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_lock_hit),
      .q   (pass_count)
   );

   assign locked   = r_locked;
   assign mismatch = r_mismatch;
   assign error    = r_error;
   assign expected = r_expected;

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - randomized and directed bench for count_checker against a behavioural model
module tb_count_checker;

   localparam int SYNC_LEN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] count_in = '0;
   logic       valid = 1'b0;

   logic        locked, mismatch, error;
   logic [3:0]  expected;
   logic [7:0]  err_count;
   logic [15:0] pass_count;

   logic        s_locked, s_mismatch, s_error;
   logic [3:0]  s_expected;
   logic [1:0]  s_err_count;
   logic [1:0]  s_pass_count;

   int n_cmp = 0;
   int n_mis = 0;

   // Model: phase 0 = idle, 1 = acquiring, 2 = locked.
   int m_phase, m_next, m_streak, m_err, m_pass, m_err_s, m_pass_s;
   bit m_pulse, m_sticky;

   always #5 clk = ~clk;

   count_checker #(.WIDTH(4), .SYNC_LEN(SYNC_LEN)) dut (
      .clk(clk), .rst(rst), .count_in(count_in), .valid(valid),
      .locked(locked), .mismatch(mismatch), .error(error), .expected(expected),
      .err_count(err_count), .pass_count(pass_count)
   );

   count_checker #(.WIDTH(4), .SYNC_LEN(SYNC_LEN), .ERR_W(2), .PASS_W(2)) dut_s (
      .clk(clk), .rst(rst), .count_in(count_in), .valid(valid),
      .locked(s_locked), .mismatch(s_mismatch), .error(s_error), .expected(s_expected),
      .err_count(s_err_count), .pass_count(s_pass_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic int sat_inc(int v, int max);
      return (v < max) ? v + 1 : max;
   endfunction

   task automatic model_update(input bit r, input bit v, input int c);
      if (r) begin
         m_phase = 0; m_next = 0; m_streak = 0; m_err = 0; m_pass = 0;
         m_err_s = 0; m_pass_s = 0; m_pulse = 0; m_sticky = 0;
         return;
      end
      m_pulse = 0;
      if (!v) return;
      if (m_phase == 0) begin
         m_next = (c + 1) % 16; m_streak = 0; m_phase = 1;
      end else if (c == m_next) begin
         m_next = (m_next + 1) % 16;
         if (m_phase == 1) begin
            m_streak++;
            if (m_streak == SYNC_LEN) m_phase = 2;
         end else begin
            m_pass   = sat_inc(m_pass, 65535);
            m_pass_s = sat_inc(m_pass_s, 3);
         end
      end else begin
         if (m_phase == 2) begin
            m_pulse = 1; m_sticky = 1;
            m_err   = sat_inc(m_err, 255);
            m_err_s = sat_inc(m_err_s, 3);
            m_phase = 1;
         end
         m_next = (c + 1) % 16; m_streak = 0;
      end
   endtask

   task automatic compare_all();
      check("locked",     locked,       m_phase == 2);
      check("mismatch",   mismatch,     m_pulse);
      check("error",      error,        m_sticky);
      check("expected",   expected,     m_next);
      check("err_count",  err_count,    m_err);
      check("pass_count", pass_count,   m_pass);
      check("s_locked",   s_locked,     m_phase == 2);
      check("s_mismatch", s_mismatch,   m_pulse);
      check("s_error",    s_error,      m_sticky);
      check("s_expected", s_expected,   m_next);
      check("s_err_sat",  s_err_count,  m_err_s);
      check("s_pass_sat", s_pass_count, m_pass_s);
   endtask

   task automatic step(input bit r, input bit v, input int c);
      rst = r; valid = v; count_in = 4'(c);
      @(posedge clk);
      model_update(r, v, c);
      #1;
      compare_all();
   endtask

   initial begin
      model_update(1'b1, 1'b0, 0);
      step(1, 0, 0);
      step(1, 1, 7);
      check("rst_expected", expected, 0);
      check("rst_locked", locked, 0);

      // Lock on 0,1,2,3
      step(0, 1, 0);
      step(0, 1, 1);
      step(0, 1, 2);
      check("t1_locked", locked, 1);
      check("t1_pass0", pass_count, 0);
      step(0, 1, 3);
      check("t1_pass1", pass_count, 1);
      check("t1_expected", expected, 4);

      // Run up to E then wrap through F->0
      for (int i = 4; i < 14; i++) step(0, 1, i);
      for (int i = 14; i < 18; i++) step(0, 1, i % 16);
      check("t2_expected", expected, 2);
      check("t2_pass", pass_count, 15);

      // Fault: expecting 5, send 7
      step(0, 1, 2); step(0, 1, 3); step(0, 1, 4);
      step(0, 1, 7);
      check("t3_mismatch", mismatch, 1);
      check("t3_err", err_count, 1);
      check("t3_expected", expected, 8);
      step(0, 1, 8);
      check("t3_pulse_gone", mismatch, 0);
      step(0, 1, 9);
      check("t3_relock", locked, 1);
      check("t3_sticky", error, 1);

      // Gaps in valid
      step(0, 1, 10);
      step(0, 0, $urandom_range(0, 15));
      step(0, 0, $urandom_range(0, 15));
      step(0, 1, 11);

      // Repeated faults saturate the narrow error counter
      for (int k = 0; k < 5; k++) begin
         step(0, 1, (m_next + 3) % 16);
         step(0, 1, m_next);
         step(0, 1, m_next);
      end
      check("t5_err_sat", s_err_count, 3);
      check("t5_pass_sat", s_pass_count, 3);

      // Reset with valid in LOCK, then SYNC-phase misses, then reset in SYNC
      step(1, 1, m_next);
      check("t6_lock_rst", expected, 0);
      step(0, 1, 0); step(0, 1, 5); step(0, 1, 9);
      check("t6_no_err", error, 0);
      step(1, 1, 10);
      check("t6_sync_rst", locked, 0);

      for (int n = 0; n < 4000; n++) begin
         bit r, v;
         int c;
         r = ($urandom_range(0, 149) == 0);
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 9) < 8) ? m_next : int'($urandom_range(0, 15));
         step(r, v, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
